// File: rtl/inst_sram_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : inst_sram_fetch_pkg
// Description : Shared constants and types for the instruction-side SRAM
//               fetch unit (NOP word, SRAM address width, default wait
//               count, enable/stall levels, FSM state encoding).
// Revision    : 1.0 - initial release
// ============================================================================
package inst_sram_fetch_pkg;

    localparam logic [31:0] NOP_WORD            = 32'h0000_0000;
    localparam int          SRAM_AW             = 20;
    localparam int          DEFAULT_WAIT_CYCLES = 1;

    // Logical enable / stall levels used on the pipeline side
    localparam logic        CHIP_ENABLE         = 1'b1;
    localparam logic        CHIP_DISABLE        = 1'b0;
    localparam logic        STOP                = 1'b1;
    localparam logic        NO_STOP             = 1'b0;

    // Active-low levels on the SRAM pins
    localparam logic        SRAM_N_ON           = 1'b0;
    localparam logic        SRAM_N_OFF          = 1'b1;
    localparam logic [3:0]  BE_N_ALL            = 4'b0000;
    localparam logic [3:0]  BE_N_NONE           = 4'b1111;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_READ = 1'b1
    } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/inst_sram_fetch.sv
`default_nettype none
// ============================================================================
// Module      : inst_sram_fetch
// Description : Instruction fetch responder. Serves the PC stage from a
//               one-entry tagged word register; on a miss it runs a
//               multi-cycle read on the base SRAM and holds a stall request
//               until the word for the current PC has been captured.
//               Optional macro IF_ARB_EN: a new read is only launched while
//               the data side does not own the SRAM (mem_busy_i low).
// Revision    : 1.0 - initial release
// ============================================================================
module inst_sram_fetch
    import inst_sram_fetch_pkg::*;
#(
    parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        pc_i,
    input  logic               ce_i,
    input  logic               mem_busy_i,
    output logic [31:0]        inst_o,
    output logic               stallreq_o,
    output logic               fetch_busy_o,
    output logic [SRAM_AW-1:0] sram_addr_o,
    input  logic [31:0]        sram_data_i,
    output logic               sram_ce_n_o,
    output logic               sram_oe_n_o,
    output logic               sram_we_n_o,
    output logic [3:0]         sram_be_n_o
);

    // Wait counter is at least one bit wide so W=0 still has a legal vector
    localparam int                CNT_W    = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(WAIT_CYCLES);

    fetch_state_t       state;
    logic [SRAM_AW-1:0] tag;
    logic               valid;
    logic [31:0]        data;
    logic [CNT_W-1:0]   wait_cnt;

    logic               hit;
    logic               grant;

    // Byte offset and upper PC bits never reach the SRAM word address
    logic               unused_pc_bits;
    assign unused_pc_bits = ^{pc_i[31:SRAM_AW+2], pc_i[1:0]};

`ifdef IF_ARB_EN
    assign grant = ~mem_busy_i;
`else
    assign grant = 1'b1;
    logic  unused_mem_busy;
    assign unused_mem_busy = mem_busy_i;
`endif

    assign hit          = (ce_i == CHIP_ENABLE) && valid && (tag == pc_i[SRAM_AW+1:2]);
    assign inst_o       = hit ? data : NOP_WORD;
    assign stallreq_o   = ((ce_i == CHIP_ENABLE) && !hit) ? STOP : NO_STOP;
    assign fetch_busy_o = (state == S_READ);
    assign sram_we_n_o  = SRAM_N_OFF;

    // Fetch FSM: launches SRAM reads on a miss, counts wait states,
    // captures the word and its tag, and handles abort and reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            tag         <= '0;
            valid       <= 1'b0;
            data        <= NOP_WORD;
            wait_cnt    <= '0;
            sram_addr_o <= '0;
            sram_ce_n_o <= SRAM_N_OFF;
            sram_oe_n_o <= SRAM_N_OFF;
            sram_be_n_o <= BE_N_NONE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (ce_i == CHIP_DISABLE) begin
                        valid <= 1'b0;
                    end else if (!hit && grant) begin
                        sram_addr_o <= pc_i[SRAM_AW+1:2];
                        sram_ce_n_o <= SRAM_N_ON;
                        sram_oe_n_o <= SRAM_N_ON;
                        sram_be_n_o <= BE_N_ALL;
                        wait_cnt    <= CNT_LOAD;
                        valid       <= 1'b0;
                        state       <= S_READ;
                    end
                end
                S_READ: begin
                    if (ce_i == CHIP_DISABLE) begin
                        // PC stage withdrew the request: drop the read
                        valid       <= 1'b0;
                        sram_ce_n_o <= SRAM_N_OFF;
                        sram_oe_n_o <= SRAM_N_OFF;
                        sram_be_n_o <= BE_N_NONE;
                        state       <= S_IDLE;
                    end else if (wait_cnt == '0) begin
                        // Tag with the latched address, not pc_i, so a PC
                        // that moved mid-read just misses and refetches
                        data        <= sram_data_i;
                        tag         <= sram_addr_o;
                        valid       <= 1'b1;
                        sram_ce_n_o <= SRAM_N_OFF;
                        sram_oe_n_o <= SRAM_N_OFF;
                        sram_be_n_o <= BE_N_NONE;
                        state       <= S_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_inst_sram_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_inst_sram_fetch
// Description : Self-checking bench for inst_sram_fetch. Three instances
//               (W=1, W=0, W=3) share one stimulus stream; each has its own
//               SRAM device model and a cycle-level behavioural model.
//               Honours IF_ARB_EN when it is defined for the build.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_sram_fetch;

    localparam int N = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce;
    logic        mem_busy;
    logic [31:0] pc;

    logic [31:0] inst  [N];
    logic        stall [N];
    logic        fbusy [N];
    logic [19:0] saddr [N];
    logic [31:0] sdata [N];
    logic        ce_n  [N];
    logic        oe_n  [N];
    logic        we_n  [N];
    logic [3:0]  be_n  [N];

    int total = 0;
    int bad   = 0;

    // Behavioural model state per instance
    bit          m_valid [N];
    bit          m_busy  [N];
    logic [19:0] m_tag   [N];
    logic [19:0] m_addr  [N];
    logic [31:0] m_data  [N];
    int          m_start [N];
    int          cyc    = 0;
    bit          chk_on = 1'b0;
    int          scnt    [N];

    always #5 clk = ~clk;

    function automatic int wait_of(input int i);
        case (i)
            0:       return 1;
            1:       return 0;
            default: return 3;
        endcase
    endfunction

    function automatic logic [31:0] sram_word(input logic [19:0] a);
        case (a)
            20'h00000: return 32'h2408_0001;
            20'h00001: return 32'h2409_0002;
            default:   return {12'h3C0, a};
        endcase
    endfunction

    function automatic bit grant_now();
`ifdef IF_ARB_EN
        return !mem_busy;
`else
        return 1'b1;
`endif
    endfunction

    for (genvar g = 0; g < N; g++) begin : g_dut
        localparam int W = (g == 0) ? 1 : ((g == 1) ? 0 : 3);
        int drv = 0;

        // SRAM device: data is only valid once W wait cycles have elapsed
        always @(posedge clk) begin
            if (ce_n[g]) drv <= 0;
            else         drv <= drv + 1;
        end

        assign sdata[g] = (!ce_n[g] && !oe_n[g] && drv >= W) ? sram_word(saddr[g]) : 32'hDEAD_BEEF;

        inst_sram_fetch #(.WAIT_CYCLES(W)) u_dut (
            .clk         (clk),
            .rst         (rst),
            .pc_i        (pc),
            .ce_i        (ce),
            .mem_busy_i  (mem_busy),
            .inst_o      (inst[g]),
            .stallreq_o  (stall[g]),
            .fetch_busy_o(fbusy[g]),
            .sram_addr_o (saddr[g]),
            .sram_data_i (sdata[g]),
            .sram_ce_n_o (ce_n[g]),
            .sram_oe_n_o (oe_n[g]),
            .sram_we_n_o (we_n[g]),
            .sram_be_n_o (be_n[g])
        );
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Per-cycle comparison of every instance against the model
    task automatic check_all();
        bit h;
        for (int i = 0; i < N; i++) begin
            h = ce && m_valid[i] && (m_tag[i] == pc[21:2]);
            chk($sformatf("inst[%0d]", i),  inst[i],          h ? m_data[i] : 32'h0);
            chk($sformatf("stall[%0d]", i), 32'(stall[i]),    32'(ce && !h));
            chk($sformatf("busy[%0d]", i),  32'(fbusy[i]),    32'(m_busy[i]));
            chk($sformatf("addr[%0d]", i),  32'(saddr[i]),    32'(m_addr[i]));
            chk($sformatf("ce_n[%0d]", i),  32'(ce_n[i]),     32'(!m_busy[i]));
            chk($sformatf("oe_n[%0d]", i),  32'(oe_n[i]),     32'(!m_busy[i]));
            chk($sformatf("be_n[%0d]", i),  32'(be_n[i]),     m_busy[i] ? 32'h0 : 32'hF);
            chk($sformatf("we_n[%0d]", i),  32'(we_n[i]),     32'h1);
        end
    endtask

    // Model: a read accepted in cycle t delivers its word at the end of
    // cycle t+1+W; ce low or reset cancels it and forgets the stored word
    task automatic model_step();
        bit h;
        for (int i = 0; i < N; i++) begin
            h = ce && m_valid[i] && (m_tag[i] == pc[21:2]);
            if (rst) begin
                m_valid[i] = 1'b0;
                m_busy[i]  = 1'b0;
                m_addr[i]  = 20'h0;
                m_tag[i]   = 20'h0;
                m_data[i]  = 32'h0;
            end else if (m_busy[i]) begin
                if (!ce) begin
                    m_busy[i]  = 1'b0;
                    m_valid[i] = 1'b0;
                end else if (cyc == m_start[i] + 1 + wait_of(i)) begin
                    m_valid[i] = 1'b1;
                    m_tag[i]   = m_addr[i];
                    m_data[i]  = sram_word(m_addr[i]);
                    m_busy[i]  = 1'b0;
                end
            end else if (!ce) begin
                m_valid[i] = 1'b0;
            end else if (!h && grant_now()) begin
                m_busy[i]  = 1'b1;
                m_start[i] = cyc;
                m_addr[i]  = pc[21:2];
                m_valid[i] = 1'b0;
            end
        end
        cyc++;
    endtask

    task automatic tick();
        @(negedge clk);
        if (chk_on) check_all();
        @(posedge clk);
        model_step();
        #1;
    endtask

    // Count stall cycles of each instance until all of them report a hit
    task automatic run_fetch();
        bit done [N];
        bit all_done;
        all_done = 1'b0;
        for (int i = 0; i < N; i++) begin
            scnt[i] = 0;
            done[i] = 1'b0;
        end
        for (int k = 0; k < 40 && !all_done; k++) begin
            #1;
            all_done = 1'b1;
            for (int i = 0; i < N; i++) begin
                if (!done[i]) begin
                    if (stall[i]) scnt[i]++;
                    else          done[i] = 1'b1;
                end
                if (!done[i]) all_done = 1'b0;
            end
            if (!all_done) tick();
        end
        if (!all_done) begin
            total++;
            bad++;
            $display("FAIL fetch_timeout: stall still high after 40 cycles (t=%0t)", $time);
        end
    endtask

    initial begin
        rst      = 1'b1;
        ce       = 1'b0;
        mem_busy = 1'b0;
        pc       = 32'h0;

        // Reset for 3 cycles with ce low
        tick();
        chk_on = 1'b1;
        tick();
        tick();
        #1;
        for (int i = 0; i < N; i++) begin
            chk($sformatf("rst_inst[%0d]", i),  inst[i],        32'h0);
            chk($sformatf("rst_stall[%0d]", i), 32'(stall[i]),  32'h0);
            chk($sformatf("rst_busy[%0d]", i),  32'(fbusy[i]),  32'h0);
            chk($sformatf("rst_ce_n[%0d]", i),  32'(ce_n[i]),   32'h1);
            chk($sformatf("rst_be_n[%0d]", i),  32'(be_n[i]),   32'hF);
            chk($sformatf("rst_addr[%0d]", i),  32'(saddr[i]),  32'h0);
        end

        // First fetch: stall is W+2 cycles
        rst = 1'b0;
        ce  = 1'b1;
        pc  = 32'h8000_0000;
        run_fetch();
        chk("f0_stall_w1", scnt[0], 3);
        chk("f0_stall_w0", scnt[1], 2);
        chk("f0_stall_w3", scnt[2], 5);
        chk("f0_inst_w1",  inst[0], 32'h2408_0001);
        chk("f0_addr_w1",  32'(saddr[0]), 32'h0);

        // Sequential fetch
        pc = 32'h8000_0004;
        run_fetch();
        chk("f1_stall_w1", scnt[0], 3);
        chk("f1_stall_w0", scnt[1], 2);
        chk("f1_stall_w3", scnt[2], 5);
        chk("f1_addr_w0",  32'(saddr[1]), 32'h1);
        chk("f1_inst_w0",  inst[1], 32'h2409_0002);
        chk("f1_we_n_w0",  32'(we_n[1]), 32'h1);

        // Data side holds the SRAM for 4 cycles at the miss
        mem_busy = 1'b1;
        pc       = 32'h8000_0008;
        repeat (4) tick();
        #1;
`ifdef IF_ARB_EN
        chk("arb_hold_ce_n",  32'(ce_n[0]),  32'h1);
        chk("arb_hold_stall", 32'(stall[0]), 32'h1);
        chk("arb_hold_addr",  32'(saddr[0]), 32'h1);
        mem_busy = 1'b0;
        run_fetch();
        chk("arb_stall_w1", scnt[0], 3);
        chk("arb_stall_w3", scnt[2], 5);
`else
        chk("noarb_inst_w1",  inst[0], 32'h3C00_0002);
        chk("noarb_stall_w1", 32'(stall[0]), 32'h0);
        mem_busy = 1'b0;
        run_fetch();
`endif
        chk("f2_inst_w3", inst[2], 32'h3C00_0002);

        // Reset during the second wait cycle of the W=3 read
        pc = 32'h8000_000C;
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("midrd_busy_w3", 32'(fbusy[2]), 32'h1);
        tick();
        chk("rstrd_ce_n_w3", 32'(ce_n[2]),  32'h1);
        chk("rstrd_oe_n_w3", 32'(oe_n[2]),  32'h1);
        chk("rstrd_inst_w3", inst[2],       32'h0);
        chk("rstrd_busy_w3", 32'(fbusy[2]), 32'h0);
        rst = 1'b0;
        run_fetch();
        chk("refetch_stall_w3", scnt[2], 5);
        chk("refetch_inst_w3",  inst[2], 32'h3C00_0003);

        // ce dropped mid-read aborts and forgets the word
        pc = 32'h8000_0010;
        tick();
        ce = 1'b0;
        #1;
        chk("abort_stall_w3", 32'(stall[2]), 32'h0);
        chk("abort_busy_pre", 32'(fbusy[2]), 32'h1);
        tick();
        chk("abort_busy_w3",  32'(fbusy[2]), 32'h0);
        chk("abort_ce_n_w3",  32'(ce_n[2]),  32'h1);
        chk("abort_inst_w3",  inst[2],       32'h0);
        ce = 1'b1;
        run_fetch();
        chk("abort_refetch_w0", scnt[1], 2);
        chk("abort_refetch_w3", scnt[2], 5);
        chk("abort_inst_after", inst[2], 32'h3C00_0004);

        // PC moves during a read: stale word must never be issued
        pc = 32'h8000_0014;
        tick();
        pc = 32'h8000_0018;
        run_fetch();
        chk("pcmove_inst_w1", inst[0], 32'h3C00_0006);
        chk("pcmove_inst_w3", inst[2], 32'h3C00_0006);

        ce = 1'b0;
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/inst_sram_fetch.md
# inst_sram_fetch

Instruction-side responder to the PC stage: accepts the fetch address and chip-enable issued each cycle and drives the board's base SRAM through a multi-cycle read. It returns the 32-bit instruction to IF/ID and raises a stall request to the control module until the word for the current PC is available. It sits between the PC register, the external base-SRAM pins and the control/stall logic; an optional arbitration hook yields the SRAM to the data side.

## Interface
- WAIT_CYCLES, 1: extra SRAM read wait states, W ≥ 0.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- pc_i  in  32  fetch address from PC stage, word-aligned.
- ce_i  in  1  fetch enable from PC stage.
- mem_busy_i  in  1  data side owns base SRAM this cycle (used only with IF_ARB_EN).
- inst_o  out  32  instruction for pc_i; 0 (NOP) when not valid.
- stallreq_o  out  1  fetch stall request to control (drives stall[0]).
- fetch_busy_o  out  1  SRAM read in flight (to data-side arbiter).
- sram_addr_o  out  20  word address, pc[21:2].
- sram_data_i  in  32  SRAM read data.
- sram_ce_n_o, sram_oe_n_o, sram_we_n_o  out  1 each  active-low controls.
- sram_be_n_o  out  4  active-low byte enables.

## Operation
- State: tag register (addr + valid), data register, FSM {IDLE, READ}, wait counter of $clog2(W+1) bits (min 1 bit).
- Hit = ce_i && valid && tag == pc_i[21:2]. inst_o = hit ? data : 0. stallreq_o = ce_i && !hit (combinational).
- IDLE: if ce_i && !hit && grant: latch pc_i[21:2] into sram_addr_o, ce_n=0, oe_n=0, be_n=0000, counter=W, valid=0, → READ. Otherwise hold, SRAM idle.
- READ: counter decrements each cycle; at counter==0 edge: data←sram_data_i, tag←sram_addr_o, valid=1, ce_n=oe_n=1, be_n=1111, → IDLE.
- ce_i low in READ: abort at next edge, → IDLE, valid=0, SRAM released.
- ce_i low in IDLE: valid=0.
- sram_we_n_o constant 1; block never writes.
- fetch_busy_o = (state==READ).
- pc_i change during READ is a protocol violation: completed word tagged with latched address, so mismatch forces refetch (no wrong instruction issued).

## Timing
- Reset values: inst_o=0, stallreq_o=0 (valid=0, ce_i treated as 0 after reset), fetch_busy_o=0, sram_addr_o=0, ce_n=oe_n=we_n=1, be_n=1111, state IDLE, valid=0.
- Miss seen at cycle t (IDLE, granted): SRAM driven cycles t+1..t+1+W; data captured at end of t+1+W; hit and stallreq_o=0 in cycle t+2+W; PC advances at that edge. Stall length W+2 cycles per sequential fetch.
- New pc_i at t+3+W is a miss: stall again at t+3+W (no back-to-back overlap).
- rst during READ: next edge → IDLE, all outputs at reset values, tag invalid.

## Configuration
- IF_ARB_EN defined: grant = !mem_busy_i; miss with mem_busy_i=1 stays in IDLE with stallreq_o=1 until released. An in-flight READ is never preempted; the data side waits on fetch_busy_o.
- Not defined: grant = 1, mem_busy_i ignored; fetch_busy_o still driven.

## Structure
- Shared header define.v: NOP word (32'h0), SRAM address width (20), default wait count, ChipEnable/ChipDisable and Stop/NoStop already present.
- Single module; no sub-module. Wait counter inline.

## Test plan
- Reset 3 cycles, ce_i=0 -> all outputs at reset values, stallreq_o=0, sram_ce_n_o=1.
- W=1, ce_i=1, pc_i=0x8000_0000, SRAM returns 0x2408_0001 -> stallreq_o high 3 cycles, then inst_o=0x2408_0001, sram_addr_o=0x00000.
- Sequential pc_i 0x8000_0000, 0x8000_0004 with W=0 -> each fetch stalls 2 cycles; sram_addr_o 0x00000 then 0x00001; we_n always 1.
- IF_ARB_EN, mem_busy_i=1 for 4 cycles at miss -> no SRAM read, stallreq_o=1; read starts cycle after release.
- rst asserted mid-READ (W=3, 2nd wait cycle) -> next edge IDLE, ce_n=oe_n=1, inst_o=0, refetch after reset.
- ce_i dropped mid-READ -> abort, valid=0, stallreq_o=0, fetch_busy_o=0 next cycle.
